// File: rtl/maxpool2_stream.sv
// maxpool2_stream: 2x2 non-overlapping max pooling over a frame-stable matrix.
// Each window's signed maximum is emitted in row-major order on a
// valid/ready stream, at up to one sample per cycle.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative results to 0.
module maxpool2_stream #(
  parameter int  IN_SIZE   = 30,
  parameter int  WIDTH_BIT = 16,
  localparam int OUT_SIZE  = IN_SIZE / 2,
  localparam int CW        = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                                               clock,
  input  logic                                               nreset,
  input  logic                                               start,
  input  logic signed [IN_SIZE-1:0][IN_SIZE-1:0][WIDTH_BIT-1:0] inpMatrix,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic signed [WIDTH_BIT-1:0]                        out_data,
  output logic [CW-1:0]                                      out_row,
  output logic [CW-1:0]                                      out_col,
  output logic                                               out_last,
  output logic                                               busy,
  output logic                                               done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(OUT_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FIN} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic                        r_start_q;
  logic                        w_start_edge;
  logic [CW-1:0]               r_row;
  logic [CW-1:0]               r_col;
  logic [CW-1:0]               w_row_next;
  logic [CW-1:0]               w_col_next;
  logic                        r_last;
  logic                        w_last_next;
  logic signed [WIDTH_BIT-1:0] r_data;
  logic                        w_load;
  logic                        w_clear;
  logic                        w_xfer;
  logic signed [WIDTH_BIT-1:0] w_a, w_b, w_c, w_d;
  logic signed [WIDTH_BIT-1:0] w_max_top, w_max_bot, w_max;
  logic signed [WIDTH_BIT-1:0] w_pool;

  assign w_start_edge = start & ~r_start_q;
  assign w_xfer       = (r_state == S_EMIT) & out_ready;
  assign w_last_next  = (w_row_next == LAST_IDX) && (w_col_next == LAST_IDX);

  assign out_data = r_data;
  assign out_row  = r_row;
  assign out_col  = r_col;
  assign out_last = r_last;

  // Next-state, window-advance and stream status decode.
  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_col_next   = r_col;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_row_next   = '0;
          w_col_next   = '0;
          w_load       = 1'b1;
          w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (w_xfer) begin
          if (r_last) begin
            // Zero the sample registers so IDLE presents all-zero outputs.
            w_clear      = 1'b1;
            w_state_next = S_FIN;
          end else begin
            w_load = 1'b1;
            if (r_col == LAST_IDX) begin
              w_col_next = '0;
              w_row_next = r_row + 1'b1;
            end else begin
              w_col_next = r_col + 1'b1;
            end
          end
        end
      end
      S_FIN: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Maximum of the window addressed by the next coordinates, so the result
  // is registered in the same cycle as the transfer that advances to it.
  always_comb begin
    w_a       = $signed(inpMatrix[{w_row_next, 1'b0}][{w_col_next, 1'b0}]);
    w_b       = $signed(inpMatrix[{w_row_next, 1'b0}][{w_col_next, 1'b1}]);
    w_c       = $signed(inpMatrix[{w_row_next, 1'b1}][{w_col_next, 1'b0}]);
    w_d       = $signed(inpMatrix[{w_row_next, 1'b1}][{w_col_next, 1'b1}]);
    w_max_top = (w_a > w_b) ? w_a : w_b;
    w_max_bot = (w_c > w_d) ? w_c : w_d;
    w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
`ifdef MAXPOOL_RELU_EN
    w_pool    = w_max[WIDTH_BIT-1] ? '0 : w_max;
`else
    w_pool    = w_max;
`endif
  end

  // State register.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Previous start level for rising-edge detection; tracks start in every state.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) r_start_q <= 1'b0;
    else        r_start_q <= start;
  end

  // Output sample registers: hold unless loading a new window or clearing.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      r_data <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_last <= 1'b0;
    end else if (w_clear) begin
      r_data <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_data <= w_pool;
      r_row  <= w_row_next;
      r_col  <= w_col_next;
      r_last <= w_last_next;
    end
  end

endmodule

// File: tb/tb_maxpool2_stream.sv
// Scoreboard bench for maxpool2_stream on a 5x5 input (2x2 pooled output).
module tb_maxpool2_stream;

  localparam int IN  = 5;
  localparam int W   = 16;
  localparam int OUT = IN / 2;
  localparam int CW  = (OUT > 1) ? $clog2(OUT) : 1;

  logic                               clock;
  logic                               nreset;
  logic                               start;
  logic signed [IN-1:0][IN-1:0][W-1:0] mat;
  logic                               out_valid;
  logic                               out_ready;
  logic signed [W-1:0]                out_data;
  logic [CW-1:0]                      out_row;
  logic [CW-1:0]                      out_col;
  logic                               out_last;
  logic                               busy;
  logic                               done;

  maxpool2_stream #(.IN_SIZE(IN), .WIDTH_BIT(W)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .start     (start),
    .inpMatrix (mat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   m[IN][IN];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   done_cnt  = 0;
  int   rdy_mode  = 2;   // 0: always ready, 1: random, 2: driven by stimulus

  task automatic check_eq(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: signed max over the 2x2 window, optional ReLU.
  function automatic int win_max(input int r, input int c);
    int mx;
    mx = m[2*r][2*c];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (m[2*r+dr][2*c+dc] > mx) mx = m[2*r+dr][2*c+dc];
`ifdef MAXPOOL_RELU_EN
    if (mx < 0) mx = 0;
`endif
    return mx;
  endfunction

  task automatic load_matrix();
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++)
        mat[i][j] = W'(m[i][j]);
  endtask

  task automatic push_expected();
    exp_t e;
    for (int r = 0; r < OUT; r++)
      for (int c = 0; c < OUT; c++) begin
        e.data = win_max(r, c);
        e.row  = r;
        e.col  = c;
        e.last = (r == OUT - 1) && (c == OUT - 1);
        exp_q.push_back(e);
      end
  endtask

  // Consumer ready generator.
  always @(posedge clock) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each transfer, checks hold and done timing.
  bit              prev_last_xfer = 0;
  bit              prev_done      = 0;
  bit              prev_stall     = 0;
  logic signed [W-1:0] held_data;
  logic [CW-1:0]   held_row, held_col;
  logic            held_last;

  always @(negedge clock) begin
    exp_t e;
    if (nreset) begin
      prev_last_xfer = 0;
      prev_done      = 0;
      prev_stall     = 0;
    end else begin
      if (prev_last_xfer || done) check_eq("done_pulse", done, prev_last_xfer);
      if (prev_done) check_eq("busy_after_done", busy, 0);
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, held_data);
        check_eq("hold_row", out_row, held_row);
        check_eq("hold_col", out_col, held_col);
        check_eq("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_sample_count", 1, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          check_eq("sample_data", out_data, e.data);
          check_eq("sample_row", out_row, e.row);
          check_eq("sample_col", out_col, e.col);
          check_eq("sample_last", out_last, e.last);
        end
      end
      if (done) done_cnt++;
      prev_last_xfer = out_valid && out_ready && out_last;
      prev_done      = done;
      prev_stall     = out_valid && !out_ready;
      held_data      = out_data;
      held_row       = out_row;
      held_col       = out_col;
      held_last      = out_last;
    end
  end

  task automatic start_frame(input bit lat_chk);
    @(posedge clock); #1 start = 1'b1;
    if (lat_chk) begin
      @(negedge clock);
      check_eq("latency_valid_same_cycle", out_valid, 0);
    end
    @(posedge clock); #1 start = 1'b0;
    if (lat_chk) begin
      @(negedge clock);
      check_eq("latency_valid_next", out_valid, 1);
      check_eq("latency_busy_next", busy, 1);
    end
  endtask

  task automatic wait_end();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !busy) break;
    end
    if (k == 2000) check_eq("frame_timeout", exp_q.size() + int'(busy), 0);
  endtask

  task automatic do_frame(input bit extra_start);
    int d0;
    load_matrix();
    push_expected();
    d0 = done_cnt;
    start_frame(1);
    if (extra_start) start_frame(0);
    wait_end();
    check_eq("done_count", done_cnt - d0, 1);
  endtask

  task automatic set_basic();
    int rows[4][4] = '{'{1, 5, -3, -7}, '{2, 0, -1, -2}, '{9, 8, -4, -5}, '{7, 6, -6, -8}};
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++)
        m[i][j] = (i < 4 && j < 4) ? rows[i][j] : 32767;
  endtask

  initial begin
    int d0;
    nreset = 1'b1; start = 1'b0; out_ready = 1'b0; mat = '0;
    for (int i = 0; i < IN; i++) for (int j = 0; j < IN; j++) m[i][j] = 0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_row", out_row, 0);
    check_eq("rst_col", out_col, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    nreset = 1'b0;
    repeat (2) @(posedge clock);

    // Basic frame, continuous ready.
    set_basic();
    rdy_mode = 0;
    do_frame(0);

    // Backpressure: ready low for the first 3 valid cycles.
    rdy_mode = 2;
    #1 out_ready = 1'b0;
    load_matrix();
    push_expected();
    d0 = done_cnt;
    start_frame(1);
    check_eq("bp_data", out_data, win_max(0, 0));
    check_eq("bp_row", out_row, 0);
    check_eq("bp_col", out_col, 0);
    repeat (2) begin
      @(negedge clock);
      check_eq("bp_hold_data", out_data, win_max(0, 0));
    end
    @(posedge clock); #1 out_ready = 1'b1; rdy_mode = 0;
    wait_end();
    check_eq("bp_done_count", done_cnt - d0, 1);

    // Start held high through the frame and beyond.
    push_expected();
    d0 = done_cnt;
    @(posedge clock); #1 start = 1'b1;
    wait_end();
    repeat (10) @(negedge clock);
    check_eq("held_done_count", done_cnt - d0, 1);
    check_eq("held_busy", busy, 0);
    @(posedge clock); #1 start = 1'b0;
    repeat (2) @(posedge clock);

    // Odd size with extremes: last row/column must be ignored.
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++)
        m[i][j] = (i == IN - 1 || j == IN - 1) ? 32767 : -32768;
    do_frame(0);

    // Reset after the second transfer, then restart.
    set_basic();
    load_matrix();
    push_expected();
    d0 = done_cnt;
    start_frame(1);
    @(posedge clock);
    @(posedge clock);
    #2 nreset = 1'b1;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_data", out_data, 0);
    check_eq("midrst_row", out_row, 0);
    check_eq("midrst_col", out_col, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 nreset = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    check_eq("midrst_idle", busy, 0);
    do_frame(0);

    // Start edge while busy, slowed by random ready.
    rdy_mode = 1;
    do_frame(1);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < IN; i++)
        for (int j = 0; j < IN; j++)
          m[i][j] = int'($signed(16'($urandom)));
      rdy_mode = int'($urandom_range(0, 1));
      do_frame(bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
